// File: rtl/inst_fetch_mem_if.sv
`default_nettype none
// ============================================================================
// inst_fetch_mem_if : PC-stage, byte-memory and IF/ID signals of the fetch unit
// Revision 1.0
// ============================================================================
interface inst_fetch_mem_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 17
);
  logic                      rdy;
  logic [ADDR_WIDTH-1:0]     if_pc;
  logic                      if_ce;
  logic                      if_stall;
  logic                      flush;
  logic [MEM_ADDR_WIDTH-1:0] mem_a;
  logic                      mem_rd_en;
  logic [7:0]                mem_din;
  logic                      id_valid;
  logic                      id_ready;
  logic [31:0]               id_inst;
  logic [ADDR_WIDTH-1:0]     id_pc;

  modport slave (
    input  rdy, if_pc, if_ce, flush, mem_din, id_ready,
    output if_stall, mem_a, mem_rd_en, id_valid, id_inst, id_pc
  );

  modport master (
    output rdy, if_pc, if_ce, flush, mem_din, id_ready,
    input  if_stall, mem_a, mem_rd_en, id_valid, id_inst, id_pc
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_mem.sv
`default_nettype none
// ============================================================================
// inst_fetch_mem : fetches a 32-bit instruction as four little-endian byte reads
// Revision 1.0
// ============================================================================
module inst_fetch_mem #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          MEM_ADDR_WIDTH = 17,
  parameter logic [31:0] NOP_INST       = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_mem_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A0   = 3'd1,
    S_A1   = 3'd2,
    S_A2   = 3'd3,
    S_A3   = 3'd4,
    S_L3   = 3'd5,
    S_OUT  = 3'd6
  } state_t;

  state_t                    r_state;
  logic [ADDR_WIDTH-1:0]     r_fetch_pc;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_a;
  logic                      r_mem_rd_en;
  logic [7:0]                r_b0, r_b1, r_b2;
  logic                      r_id_valid;
  logic [31:0]               r_id_inst;
  logic [ADDR_WIDTH-1:0]     r_id_pc;

  logic [MEM_ADDR_WIDTH-1:0] w_base;
  logic                      w_take_new;
  logic                      w_accept;

  assign w_base     = r_fetch_pc[MEM_ADDR_WIDTH-1:0];
  // A new pc is taken from IDLE, or from OUT in the same edge the instruction is consumed
  assign w_take_new = (r_state == S_IDLE) || ((r_state == S_OUT) && bus.id_ready);
  assign w_accept   = w_take_new && bus.if_ce && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= '0;
      r_mem_a     <= '0;
      r_mem_rd_en <= 1'b0;
      r_b0        <= 8'h00;
      r_b1        <= 8'h00;
      r_b2        <= 8'h00;
      r_id_valid  <= 1'b0;
      r_id_inst   <= NOP_INST;
      r_id_pc     <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        r_state     <= S_IDLE;
        r_id_valid  <= 1'b0;
        r_mem_rd_en <= 1'b0;
      end else begin
        case (r_state)
          S_A0: begin
            r_mem_a <= w_base + MEM_ADDR_WIDTH'(1);
            r_state <= S_A1;
          end
          S_A1: begin
            r_b0    <= bus.mem_din;
            r_mem_a <= w_base + MEM_ADDR_WIDTH'(2);
            r_state <= S_A2;
          end
          S_A2: begin
            r_b1    <= bus.mem_din;
            r_mem_a <= w_base + MEM_ADDR_WIDTH'(3);
            r_state <= S_A3;
          end
          S_A3: begin
            r_b2        <= bus.mem_din;
            r_mem_rd_en <= 1'b0;
            r_state     <= S_L3;
          end
          S_L3: begin
            r_id_inst  <= {bus.mem_din, r_b2, r_b1, r_b0};
            r_id_pc    <= r_fetch_pc;
            r_id_valid <= 1'b1;
            r_state    <= S_OUT;
          end
          S_OUT: begin
            if (bus.id_ready) begin
              r_id_valid <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
          default: ;
        endcase
        if (w_accept) begin
          r_fetch_pc  <= bus.if_pc;
          r_mem_a     <= bus.if_pc[MEM_ADDR_WIDTH-1:0];
          r_mem_rd_en <= 1'b1;
          r_state     <= S_A0;
        end
      end
    end
  end

  assign bus.if_stall  = (r_state != S_IDLE) && !((r_state == S_OUT) && bus.id_ready);
  assign bus.mem_a     = r_mem_a;
  assign bus.mem_rd_en = r_mem_rd_en;
  assign bus.id_valid  = r_id_valid;
  assign bus.id_inst   = r_id_inst;
  assign bus.id_pc     = r_id_pc;

endmodule
`default_nettype wire
